// File: rtl/dt_skeleton_extract_if.sv
// Bus bundle for dt_skeleton_extract: start/done handshake, result RAM read
// port and skeleton RAM write port. The skeleton extractor is the master.
interface dt_skeleton_extract_if;
  logic        start;
  logic        done;
  logic        res_rd;
  logic [13:0] res_addr;
  logic [7:0]  res_di;
  logic        sk_wr;
  logic [9:0]  sk_addr;
  logic [15:0] sk_do;

  modport master (
    input  start, res_di,
    output done, res_rd, res_addr, sk_wr, sk_addr, sk_do
  );

  modport slave (
    output start, res_di,
    input  done, res_rd, res_addr, sk_wr, sk_addr, sk_do
  );
endinterface

// File: rtl/dt_skeleton_extract.sv
// dt_skeleton_extract: scans the 128x128 distance-transform result RAM and
// writes a packed 1-bit skeleton (ridge) image, 16 pixels per word.
// A pixel is a ridge pixel when it is non-zero and >= every neighbour.
// Optional macro SK_8CONN_EN: compare against 8 neighbours instead of 4.
module dt_skeleton_extract (
  input logic                   clk,
  input logic                   reset,
  dt_skeleton_extract_if.master bus
);
`ifdef SK_8CONN_EN
  localparam int NSLOT = 8;
`else
  localparam int NSLOT = 4;
`endif
  localparam logic [2:0] LAST_SLOT = 3'(NSLOT - 1);

  typedef enum logic [2:0] {IDLE, READ_C, READ_N, EVAL, WRITE, DONE} state_t;

  state_t      state, state_nxt;
  logic [13:0] p;
  logic [7:0]  c_val;
  logic [7:0]  m_val;
  logic [2:0]  slot;
  logic [15:0] word_buf;

  logic [7:0]  dr, dc;
  logic [7:0]  nb_row, nb_col;
  logic        nb_in;
  logic [13:0] nb_addr;
  logic        eval_bit;

  function automatic logic [7:0] max_u8(input logic [7:0] a, input logic [7:0] b);
    return (a >= b) ? a : b;
  endfunction

  // Row/column offset of the neighbour visited in the current slot (two's complement, 8 bit)
  always_comb begin
    dr = 8'h00;
    dc = 8'h00;
`ifdef SK_8CONN_EN
    case (slot)
      3'd0: begin dr = 8'hFF; dc = 8'hFF; end
      3'd1: begin dr = 8'hFF; dc = 8'h00; end
      3'd2: begin dr = 8'hFF; dc = 8'h01; end
      3'd3: begin dr = 8'h00; dc = 8'hFF; end
      3'd4: begin dr = 8'h00; dc = 8'h01; end
      3'd5: begin dr = 8'h01; dc = 8'hFF; end
      3'd6: begin dr = 8'h01; dc = 8'h00; end
      default: begin dr = 8'h01; dc = 8'h01; end
    endcase
`else
    case (slot)
      3'd0: begin dr = 8'hFF; dc = 8'h00; end
      3'd1: begin dr = 8'h00; dc = 8'hFF; end
      3'd2: begin dr = 8'h00; dc = 8'h01; end
      3'd3: begin dr = 8'h01; dc = 8'h00; end
      default: begin dr = 8'h00; dc = 8'h00; end
    endcase
`endif
  end

  // Stepping off any image edge (-1 or 128) sets bit 7, which flags the neighbour as outside
  assign nb_row   = {1'b0, p[13:7]} + dr;
  assign nb_col   = {1'b0, p[6:0]} + dc;
  assign nb_in    = ~nb_row[7] & ~nb_col[7];
  assign nb_addr  = {nb_row[6:0], nb_col[6:0]};
  assign eval_bit = (c_val != 8'd0) && (c_val >= m_val);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode and all outputs, which are zero outside their active states
  always_comb begin
    state_nxt    = state;
    bus.done     = 1'b0;
    bus.res_rd   = 1'b0;
    bus.res_addr = 14'd0;
    bus.sk_wr    = 1'b0;
    bus.sk_addr  = 10'd0;
    bus.sk_do    = 16'd0;
    case (state)
      IDLE: if (bus.start) state_nxt = READ_C;
      READ_C: begin
        bus.res_rd   = 1'b1;
        bus.res_addr = p;
        state_nxt    = (bus.res_di == 8'd0) ? EVAL : READ_N;
      end
      READ_N: begin
        if (nb_in) begin
          bus.res_rd   = 1'b1;
          bus.res_addr = nb_addr;
        end
        if (slot == LAST_SLOT) state_nxt = EVAL;
      end
      EVAL: state_nxt = (p[3:0] == 4'hF) ? WRITE : READ_C;
      WRITE: begin
        bus.sk_wr   = 1'b1;
        bus.sk_addr = p[13:4];
        bus.sk_do   = word_buf;
        state_nxt   = (p == 14'h3FFF) ? DONE : READ_C;
      end
      DONE: begin
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Pixel index, centre/max latches, slot counter and the word being assembled
  always_ff @(posedge clk) begin
    if (reset) begin
      p        <= 14'd0;
      c_val    <= 8'd0;
      m_val    <= 8'd0;
      slot     <= 3'd0;
      word_buf <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          p        <= 14'd0;
          word_buf <= 16'd0;
        end
        READ_C: begin
          c_val <= bus.res_di;
          m_val <= 8'd0;
          slot  <= 3'd0;
        end
        READ_N: begin
          if (nb_in) m_val <= max_u8(m_val, bus.res_di);
          slot <= slot + 3'd1;
        end
        EVAL: begin
          word_buf[p[3:0]] <= eval_bit;
          if (p[3:0] != 4'hF) p <= p + 14'd1;
        end
        WRITE: begin
          word_buf <= 16'd0;
          if (p != 14'h3FFF) p <= p + 14'd1;
        end
        default: ;
      endcase
    end
  end
endmodule
